// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: R-type funct codes and FSM states.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package mdu_pkg;

    localparam logic [5:0] FN_MULT  = 6'b011000;
    localparam logic [5:0] FN_MULTU = 6'b011001;
    localparam logic [5:0] FN_DIV   = 6'b011010;
    localparam logic [5:0] FN_DIVU  = 6'b011011;
    localparam logic [5:0] FN_MTHI  = 6'b010001;
    localparam logic [5:0] FN_MTLO  = 6'b010011;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_MUL     = 2'd1,
        ST_DIV_RUN = 2'd2,
        ST_DIV_FIX = 2'd3
    } state_t;

endpackage

// File: rtl/mdu_udiv_step.sv
// One radix-2 restoring division step on unsigned magnitudes.
// Latency: combinational.
// Backpressure: none.
module mdu_udiv_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem,
    input  logic [WIDTH-1:0] shift_in,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_nxt,
    output logic [WIDTH-1:0] shift_nxt
);

    logic [WIDTH:0] partial;
    logic [WIDTH:0] diff;
    logic           ge;

    // rem < divisor always holds, so a successful subtract fits back in WIDTH bits.
    assign partial   = {rem, shift_in[WIDTH-1]};
    assign diff      = partial - {1'b0, divisor};
    assign ge        = ~diff[WIDTH];
    assign rem_nxt   = ge ? diff[WIDTH-1:0] : partial[WIDTH-1:0];
    assign shift_nxt = {shift_in[WIDTH-2:0], ge};

endmodule

// File: rtl/mdu_hilo.sv
// MIPS multiply/divide unit with architectural HI/LO registers.
// Latency: MTHI/MTLO 1 edge; MULT/MULTU 1 busy cycle; DIV/DIVU 33 busy cycles; done pulses after the write.
// Backpressure: busy blocks acceptance; op_valid is ignored while busy and the upstream holds the op.
module mdu_hilo
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             op_valid,
    input  logic [5:0]       op_funct,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] op_x;      // raw op_a: multiplicand, or dividend for div-by-zero
    logic [WIDTH-1:0] op_y;      // multiplier, or divisor magnitude
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] quo;       // dividend shifts out as quotient shifts in
    logic             mul_signed;
    logic             q_neg;
    logic             r_neg;

    logic             is_mul;
    logic             is_div;
    logic             div_signed;
    logic [WIDTH-1:0] rem_step;
    logic [WIDTH-1:0] quo_step;
    logic [WIDTH:0]   mx;
    logic [WIDTH:0]   my;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0] quo_fix;
    logic [WIDTH-1:0] rem_fix;

    assign is_mul     = (op_funct == FN_MULT) || (op_funct == FN_MULTU);
    assign is_div     = (op_funct == FN_DIV)  || (op_funct == FN_DIVU);
    assign div_signed = (op_funct == FN_DIV);
    assign busy       = (state != ST_IDLE);

    assign mx   = {mul_signed & op_x[WIDTH-1], op_x};
    assign my   = {mul_signed & op_y[WIDTH-1], op_y};
    assign prod = {{(WIDTH-1){mx[WIDTH]}}, mx} * {{(WIDTH-1){my[WIDTH]}}, my};

    assign quo_fix = q_neg ? -quo : quo;
    assign rem_fix = r_neg ? -rem : rem;

    mdu_udiv_step #(.WIDTH(WIDTH)) u_step (
        .rem       (rem),
        .shift_in  (quo),
        .divisor   (op_y),
        .rem_nxt   (rem_step),
        .shift_nxt (quo_step)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (op_valid && is_mul)      state_nxt = ST_MUL;
                else if (op_valid && is_div) state_nxt = ST_DIV_RUN;
            end
            ST_MUL:     state_nxt = ST_IDLE;
            ST_DIV_RUN: if (cnt == CNT_LAST) state_nxt = ST_DIV_FIX;
            ST_DIV_FIX: state_nxt = ST_IDLE;
            default:    state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hi         <= '0;
            lo         <= '0;
            done       <= 1'b0;
            cnt        <= '0;
            op_x       <= '0;
            op_y       <= '0;
            rem        <= '0;
            quo        <= '0;
            mul_signed <= 1'b0;
            q_neg      <= 1'b0;
            r_neg      <= 1'b0;
        end else begin
            done <= (state == ST_MUL) || (state == ST_DIV_FIX);
            case (state)
                ST_IDLE: begin
                    if (op_valid) begin
                        if (op_funct == FN_MTHI) hi <= op_a;
                        if (op_funct == FN_MTLO) lo <= op_a;
                        if (is_mul) begin
                            op_x       <= op_a;
                            op_y       <= op_b;
                            mul_signed <= (op_funct == FN_MULT);
                        end
                        if (is_div) begin
                            op_x  <= op_a;
                            op_y  <= (div_signed && op_b[WIDTH-1]) ? -op_b : op_b;
                            quo   <= (div_signed && op_a[WIDTH-1]) ? -op_a : op_a;
                            rem   <= '0;
                            cnt   <= '0;
                            q_neg <= div_signed & (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
                            r_neg <= div_signed & op_a[WIDTH-1];
                        end
                    end
                end
                ST_MUL: {hi, lo} <= prod;
                ST_DIV_RUN: begin
                    rem <= rem_step;
                    quo <= quo_step;
                    cnt <= cnt + 1'b1;
                end
                ST_DIV_FIX: begin
                    // A zero divisor leaves the dividend untouched in HI, regardless of sign mode.
                    if (op_y == '0) begin
                        lo <= '1;
                        hi <= op_x;
                    end else begin
                        lo <= quo_fix;
                        hi <= rem_fix;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mdu_hilo.sv
// Self-checking bench for mdu_hilo: directed corner cases plus randomized ops against an arithmetic model.
module tb_mdu_hilo;
    import mdu_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        op_valid = 1'b0;
    logic [5:0]  op_funct = '0;
    logic [31:0] op_a = '0;
    logic [31:0] op_b = '0;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] exp_hi  = '0;
    logic [31:0] exp_lo  = '0;

    mdu_hilo #(.WIDTH(32)) dut (
        .clk      (clk),
        .rst      (rst),
        .op_valid (op_valid),
        .op_funct (op_funct),
        .op_a     (op_a),
        .op_b     (op_b),
        .busy     (busy),
        .done     (done),
        .hi       (hi),
        .lo       (lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%h, expected 0x%h", tag, got, exp);
        end
    endtask

    // Architectural result of one op, straight from the ISA arithmetic.
    task automatic model(input logic [5:0] fn, input logic [31:0] a, input logic [31:0] b);
        longint      sp;
        logic [63:0] up;
        longint      q;
        longint      r;
        case (fn)
            FN_MULT: begin
                sp = longint'($signed(a)) * longint'($signed(b));
                {exp_hi, exp_lo} = sp;
            end
            FN_MULTU: begin
                up = {32'b0, a} * {32'b0, b};
                {exp_hi, exp_lo} = up;
            end
            FN_DIV, FN_DIVU: begin
                if (b == 0) begin
                    exp_lo = 32'hFFFF_FFFF;
                    exp_hi = a;
                end else if (fn == FN_DIV) begin
                    q = longint'($signed(a)) / longint'($signed(b));
                    r = longint'($signed(a)) % longint'($signed(b));
                    exp_lo = q[31:0];
                    exp_hi = r[31:0];
                end else begin
                    exp_lo = a / b;
                    exp_hi = a % b;
                end
            end
            FN_MTHI: exp_hi = a;
            FN_MTLO: exp_lo = a;
            default: ;
        endcase
    endtask

    // Called #1 after a rising edge; returns #1 after the edge where done is high (or the op edge).
    task automatic do_op(input logic [5:0] fn, input logic [31:0] a, input logic [31:0] b,
                         input bit hold_mtlo);
        int          busy_cnt;
        int          guard;
        int          exp_busy;
        logic [63:0] old;
        old      = {exp_hi, exp_lo};
        exp_busy = (fn == FN_MULT || fn == FN_MULTU) ? 1 :
                   (fn == FN_DIV  || fn == FN_DIVU)  ? 33 : 0;
        model(fn, a, b);
        op_valid = 1'b1;
        op_funct = fn;
        op_a     = a;
        op_b     = b;
        @(posedge clk); #1;
        op_valid = 1'b0;
        if (exp_busy == 0) begin
            chk("nonmd_busy", busy, 0);
            chk("nonmd_done", done, 0);
            chk("nonmd_hilo", {hi, lo}, {exp_hi, exp_lo});
        end else begin
            if (hold_mtlo) begin
                op_valid = 1'b1;
                op_funct = FN_MTLO;
                op_a     = 32'h0BAD_C0DE;
            end
            busy_cnt = 0;
            guard    = 0;
            while (!done && guard < 80) begin
                if (busy) busy_cnt++;
                chk("hold_hilo", {hi, lo}, old);
                @(posedge clk); #1;
                guard++;
            end
            op_valid = 1'b0;
            chk("done_seen", done, 1);
            chk("busy_cycles", busy_cnt, exp_busy);
            chk("result_hilo", {hi, lo}, {exp_hi, exp_lo});
        end
    endtask

    task automatic dir(input string tag, input logic [5:0] fn, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el);
        do_op(fn, a, b, 1'b0);
        chk(tag, {hi, lo}, {eh, el});
    endtask

    function automatic logic [31:0] rnd_opnd();
        case ($urandom_range(0, 7))
            0:       return 32'h0000_0000;
            1:       return 32'h0000_0001;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return 32'($urandom_range(0, 20));
            default: return $urandom();
        endcase
    endfunction

    initial begin
        logic [5:0]  fn;
        logic [31:0] a;
        logic [31:0] b;
        bit          saw_done;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_hilo", {hi, lo}, 64'h0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        rst = 1'b0;

        dir("mthi",    FN_MTHI,  32'h1234_5678, 32'h0, 32'h1234_5678, 32'h0000_0000);
        dir("mtlo",    FN_MTLO,  32'h9ABC_DEF0, 32'h0, 32'h1234_5678, 32'h9ABC_DEF0);
        dir("mult",    FN_MULT,  32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
        dir("multu",   FN_MULTU, 32'hFFFF_FFFE, 32'd3, 32'h0000_0002, 32'hFFFF_FFFA);
        dir("div_neg", FN_DIV,   32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        dir("divu",    FN_DIVU,  32'd100,       32'd7, 32'd2,         32'd14);
        dir("divu_z",  FN_DIVU,  32'h55,        32'd0, 32'h55,        32'hFFFF_FFFF);
        dir("div_z",   FN_DIV,   32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 32'hFFFF_FFFF);
        dir("div_ovf", FN_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0,  32'h8000_0000);
        // Issued in the done cycle of the previous divide.
        dir("b2b_mul", FN_MULT,  32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB);

        // MTLO held on op_valid throughout a divide must not reach LO.
        do_op(FN_DIV, 32'd100, 32'd7, 1'b1);
        chk("mtlo_ignored", lo, 32'd14);

        // Abort a divide partway through with reset.
        op_valid = 1'b1;
        op_funct = FN_DIV;
        op_a     = 32'd1000;
        op_b     = 32'd3;
        @(posedge clk); #1;
        op_valid = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("abort_hilo", {hi, lo}, 64'h0);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        exp_hi   = '0;
        exp_lo   = '0;
        saw_done = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            saw_done |= done;
        end
        chk("abort_no_done", saw_done, 0);
        chk("abort_hilo_hold", {hi, lo}, 64'h0);

        for (int i = 0; i < 3000; i++) begin
            a = rnd_opnd();
            b = rnd_opnd();
            case ($urandom_range(0, 9))
                0, 1:    fn = FN_DIV;
                2:       fn = FN_DIVU;
                3, 4:    fn = FN_MULT;
                5:       fn = FN_MULTU;
                6:       fn = FN_MTHI;
                7:       fn = FN_MTLO;
                8:       fn = 6'b100000 | 6'($urandom_range(0, 15));
                default: fn = FN_MULTU;
            endcase
            do_op(fn, a, b, 1'b0);
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk); #1;
                chk("idle_done", done, 0);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
